// File: rtl/rv32_types.sv
// Shared RV32 types: memory port operations/requests and LSU fault codes,
// plus small decode helpers used by the load/store unit.
package rv32_types;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } memory_op_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    memory_op_t  op;
  } memory_request_t;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_ACCESS     = 2'd2
  } lsu_fault_t;

  localparam memory_request_t MEM_REQUEST_IDLE = '{addr: 32'h0000_0000, data: 32'h0000_0000, op: MEM_NOP};

  function automatic logic op_is_load(input memory_op_t op);
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: op_is_load = 1'b1;
      default:                                 op_is_load = 1'b0;
    endcase
  endfunction

  // Byte accesses can never be misaligned; halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic op_is_misaligned(input memory_op_t op, input logic [1:0] lane);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: op_is_misaligned = lane[0];
      MEM_LW, MEM_SW:          op_is_misaligned = (lane != 2'b00);
      default:                 op_is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_lsu_if.sv
// Execute-stage request, memory port B and writeback response bundle of the LSU.
interface rv32_lsu_if;
  import rv32_types::*;

  logic            req_valid;
  logic            req_ready;
  memory_op_t      req_op;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [4:0]      req_rd;
  memory_request_t mem_request;
  logic            mem_ready;
  logic [31:0]     mem_data;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic [4:0]      resp_rd;
  logic            resp_is_load;
  lsu_fault_t      resp_fault;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd,
    input  mem_ready, mem_data, resp_ready,
    output req_ready, mem_request,
    output resp_valid, resp_data, resp_rd, resp_is_load, resp_fault
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd,
    output mem_ready, mem_data, resp_ready,
    input  req_ready, mem_request,
    input  resp_valid, resp_data, resp_rd, resp_is_load, resp_fault
  );

endinterface

// File: rtl/rv32_load_formatter.sv
// Selects the addressed byte/half of a memory word and sign/zero-extends it.
// Non-load operations produce zero.
module rv32_load_formatter
  import rv32_types::*;
(
  input  memory_op_t  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension according to the load flavour.
  always_comb begin
    case (lane)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (op)
      MEM_LB:  result = {{24{byte_s[7]}}, byte_s};
      MEM_LBU: result = {24'h00_0000, byte_s};
      MEM_LH:  result = {{16{half_s[15]}}, half_s};
      MEM_LHU: result = {16'h0000, half_s};
      MEM_LW:  result = word;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// Single-outstanding load/store unit in front of memory port B: alignment and
// range checks, one-cycle load latency, and a skid register for writeback stalls.
module rv32_lsu
  import rv32_types::*;
(
  input logic       clk,
  input logic       resetn,
  rv32_lsu_if.slave lsu
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } lsu_state_t;

  lsu_state_t  state_r;
  memory_op_t  op_r;
  logic [1:0]  lane_r;
  logic [4:0]  rd_r;
  lsu_fault_t  fault_r;
  logic [31:0] skid_data_r;

  logic        req_ready_s;
  logic        accept_s;
  lsu_fault_t  fault_s;
  logic [31:0] fmt_s;
  logic [31:0] wait_data_s;

  // Request side: readiness, accept decode, fault classification and forwarding.
  always_comb begin
    case (state_r)
      ST_IDLE: req_ready_s = 1'b1;
      ST_WAIT: req_ready_s = lsu.resp_ready;
      default: req_ready_s = 1'b0;
    endcase
    accept_s = lsu.req_valid && req_ready_s && (lsu.req_op != MEM_NOP);
    if (op_is_misaligned(lsu.req_op, lsu.req_addr[1:0])) begin
      fault_s = FAULT_MISALIGNED;
    end else if (!lsu.mem_ready) begin
      fault_s = FAULT_ACCESS;
    end else begin
      fault_s = FAULT_NONE;
    end
    lsu.mem_request = MEM_REQUEST_IDLE;
    if (accept_s) begin
      lsu.mem_request.addr = lsu.req_addr;
      lsu.mem_request.data = lsu.req_wdata;
      lsu.mem_request.op   = (fault_s == FAULT_NONE) ? lsu.req_op : MEM_NOP;
    end else begin
      lsu.mem_request = MEM_REQUEST_IDLE;
    end
    lsu.req_ready = req_ready_s;
  end

  rv32_load_formatter u_fmt (
    .op     (op_r),
    .lane   (lane_r),
    .word   (lsu.mem_data),
    .result (fmt_s)
  );

  // Response side: live from memory in WAIT, from the skid register in HOLD.
  always_comb begin
    wait_data_s = (fault_r == FAULT_NONE) ? fmt_s : 32'h0000_0000;
    case (state_r)
      ST_WAIT: begin
        lsu.resp_valid   = 1'b1;
        lsu.resp_data    = wait_data_s;
        lsu.resp_rd      = rd_r;
        lsu.resp_is_load = op_is_load(op_r);
        lsu.resp_fault   = fault_r;
      end
      ST_HOLD: begin
        lsu.resp_valid   = 1'b1;
        lsu.resp_data    = skid_data_r;
        lsu.resp_rd      = rd_r;
        lsu.resp_is_load = op_is_load(op_r);
        lsu.resp_fault   = fault_r;
      end
      default: begin
        lsu.resp_valid   = 1'b0;
        lsu.resp_data    = 32'h0000_0000;
        lsu.resp_rd      = 5'd0;
        lsu.resp_is_load = 1'b0;
        lsu.resp_fault   = FAULT_NONE;
      end
    endcase
  end

  // Sequencer plus capture of the accepted access; the fields stay put while HOLD waits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      op_r        <= MEM_NOP;
      lane_r      <= 2'b00;
      rd_r        <= 5'd0;
      fault_r     <= FAULT_NONE;
      skid_data_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= accept_s ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: begin
          if (lsu.resp_ready) begin
            state_r <= accept_s ? ST_WAIT : ST_IDLE;
          end else begin
            state_r     <= ST_HOLD;
            skid_data_r <= wait_data_s;
          end
        end
        ST_HOLD: begin
          state_r <= lsu.resp_ready ? ST_IDLE : ST_HOLD;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      if (accept_s) begin
        op_r    <= lsu.req_op;
        lane_r  <= lsu.req_addr[1:0];
        rd_r    <= lsu.req_rd;
        fault_r <= fault_s;
      end else begin
        op_r    <= op_r;
        lane_r  <= lane_r;
        rd_r    <= rd_r;
        fault_r <= fault_r;
      end
    end
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// Directed bench for rv32_lsu with a behavioural memory on port B and a
// response scoreboard fed at request acceptance.
module tb_rv32_lsu;
  import rv32_types::*;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        is_load;
    logic [1:0]  fault;
  } resp_t;

  logic clk;
  logic resetn;
  rv32_lsu_if lsu ();

  logic [31:0] mem [0:1023];
  resp_t       sb_q[$];
  logic        fresh;
  int          vectors;
  int          miscompares;

  rv32_lsu dut (
    .clk    (clk),
    .resetn (resetn),
    .lsu    (lsu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4 KiB memory: in range when addr < 0x1000, synchronous read, lane-steered write.
  assign lsu.mem_ready = (lsu.mem_request.addr < 32'h0000_1000);

  always @(posedge clk) begin
    lsu.mem_data <= mem[lsu.mem_request.addr[11:2]];
    if (lsu.mem_ready) begin
      case (lsu.mem_request.op)
        MEM_SB: mem[lsu.mem_request.addr[11:2]][{lsu.mem_request.addr[1:0], 3'b000} +: 8] <= lsu.mem_request.data[7:0];
        MEM_SH: mem[lsu.mem_request.addr[11:2]][{lsu.mem_request.addr[1], 4'b0000} +: 16] <= lsu.mem_request.data[15:0];
        MEM_SW: mem[lsu.mem_request.addr[11:2]] <= lsu.mem_request.data;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input memory_op_t op, input logic [1:0] lane, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * lane));
    h = 16'(w >> (16 * lane[1]));
    case (op)
      MEM_LB:  return {{24{b[7]}}, b};
      MEM_LBU: return {24'h0, b};
      MEM_LH:  return {{16{h[15]}}, h};
      MEM_LHU: return {16'h0, h};
      MEM_LW:  return w;
      default: return 32'h0;
    endcase
  endfunction

  // One clock: drive at negedge, check just before the posedge, advance.
  task automatic step(input logic valid, input memory_op_t op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd, input logic rready);
    logic            exp_valid;
    logic            exp_rdy;
    logic            acc;
    logic            mis;
    logic [1:0]      flt;
    resp_t           e;
    memory_request_t exp_req;
    lsu.req_valid  = valid;
    lsu.req_op     = op;
    lsu.req_addr   = addr;
    lsu.req_wdata  = wdata;
    lsu.req_rd     = rd;
    lsu.resp_ready = rready;
    #4;
    exp_valid = (sb_q.size() != 0);
    exp_rdy   = (sb_q.size() == 0) || (fresh && rready);
    chk("resp_valid", 68'(lsu.resp_valid), 68'(exp_valid));
    chk("req_ready", 68'(lsu.req_ready), 68'(exp_rdy));
    if (exp_valid) begin
      e = sb_q[0];
      chk("resp_data", 68'(lsu.resp_data), 68'(e.data));
      chk("resp_rd", 68'(lsu.resp_rd), 68'(e.rd));
      chk("resp_is_load", 68'(lsu.resp_is_load), 68'(e.is_load));
      chk("resp_fault", 68'(lsu.resp_fault), 68'(e.fault));
      if (rready) begin
        void'(sb_q.pop_front());
      end else begin
        fresh = 1'b0;
      end
    end
    acc = valid && exp_rdy && (op != MEM_NOP);
    exp_req = '{addr: 32'h0, data: 32'h0, op: MEM_NOP};
    if (acc) begin
      mis = ((op == MEM_LH || op == MEM_LHU || op == MEM_SH) && addr[0]) ||
            ((op == MEM_LW || op == MEM_SW) && addr[1:0] != 2'b00);
      flt = mis ? 2'd1 : (addr >= 32'h0000_1000) ? 2'd2 : 2'd0;
      exp_req.addr = addr;
      exp_req.data = wdata;
      exp_req.op   = (flt == 2'd0) ? op : MEM_NOP;
      e.data    = (flt == 2'd0) ? model_load(op, addr[1:0], mem[addr[11:2]]) : 32'h0;
      e.rd      = rd;
      e.is_load = (op == MEM_LB || op == MEM_LH || op == MEM_LW || op == MEM_LBU || op == MEM_LHU);
      e.fault   = flt;
      sb_q.push_back(e);
      fresh = 1'b1;
    end
    chk("mem_request", 68'(lsu.mem_request), 68'(exp_req));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    fresh = 1'b0;
    resetn = 1'b0;
    lsu.req_valid = 1'b0;
    lsu.req_op = MEM_NOP;
    lsu.req_addr = 32'h0;
    lsu.req_wdata = 32'h0;
    lsu.req_rd = 5'd0;
    lsu.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 68'(lsu.resp_valid), 68'(1'b0));
    chk("rst_req_ready", 68'(lsu.req_ready), 68'(1'b1));
    chk("rst_resp_data", 68'(lsu.resp_data), 68'(32'h0));
    chk("rst_resp_rd", 68'(lsu.resp_rd), 68'(5'd0));
    chk("rst_resp_is_load", 68'(lsu.resp_is_load), 68'(1'b0));
    chk("rst_resp_fault", 68'(lsu.resp_fault), 68'(FAULT_NONE));
    chk("rst_mem_request", 68'(lsu.mem_request), 68'(0));
    resetn = 1'b1;
    @(negedge clk);

    // Preload then back-to-back formatted loads of 0x80FF_1234.
    step(1'b1, MEM_SW,  32'h100, 32'h80FF_1234, 5'd1, 1'b1);
    step(1'b1, MEM_LB,  32'h103, 32'h0, 5'd2, 1'b1);
    step(1'b1, MEM_LHU, 32'h102, 32'h0, 5'd3, 1'b1);
    step(1'b1, MEM_LH,  32'h102, 32'h0, 5'd4, 1'b1);
    step(1'b1, MEM_LW,  32'h100, 32'h0, 5'd5, 1'b1);
    // Misaligned store must not write.
    step(1'b1, MEM_SW,  32'h101, 32'h5555_5555, 5'd6, 1'b1);
    step(1'b0, MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b1);
    chk("mem_unchanged", 68'(mem[32'h100 >> 2]), 68'(32'h80FF_1234));
    // Out-of-range load, then a NOP that must be consumed silently.
    step(1'b1, MEM_LW,  32'h2000, 32'h0, 5'd7, 1'b1);
    step(1'b1, MEM_NOP, 32'h100, 32'h0, 5'd8, 1'b1);
    step(1'b0, MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b1);
    // Store-to-load forwarding through memory, sub-word stores and loads.
    step(1'b1, MEM_SW,  32'h10, 32'hDEAD_BEEF, 5'd10, 1'b1);
    step(1'b1, MEM_LW,  32'h10, 32'h0, 5'd11, 1'b1);
    step(1'b1, MEM_SB,  32'h21, 32'h0000_00AB, 5'd12, 1'b1);
    step(1'b1, MEM_LB,  32'h21, 32'h0, 5'd13, 1'b1);
    step(1'b1, MEM_LBU, 32'h21, 32'h0, 5'd14, 1'b1);
    step(1'b1, MEM_SH,  32'h22, 32'hFFFF_9234, 5'd15, 1'b1);
    step(1'b1, MEM_LHU, 32'h22, 32'h0, 5'd16, 1'b1);
    step(1'b1, MEM_LH,  32'h23, 32'h0, 5'd17, 1'b1);
    step(1'b0, MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b1);
    // Writeback stall: WAIT -> HOLD for three cycles, then retire and resume.
    step(1'b1, MEM_LW,  32'h10, 32'h0, 5'd20, 1'b0);
    repeat (3) step(1'b1, MEM_LW, 32'h100, 32'h0, 5'd21, 1'b0);
    step(1'b1, MEM_LW,  32'h100, 32'h0, 5'd21, 1'b1);
    step(1'b1, MEM_LW,  32'h100, 32'h0, 5'd21, 1'b1);
    step(1'b0, MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b1);
    // Reset while a load is in WAIT: response vanishes and never reappears.
    step(1'b1, MEM_LW,  32'h100, 32'h0, 5'd9, 1'b1);
    lsu.req_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("wait_rst_resp_valid", 68'(lsu.resp_valid), 68'(1'b0));
    chk("wait_rst_req_ready", 68'(lsu.req_ready), 68'(1'b1));
    sb_q.delete();
    fresh = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) step(1'b0, MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b1);
    chk("sb_empty", 68'(sb_q.size()), 68'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv32_lsu.md
# rv32_lsu

Load/store unit between the execute stage and data port B of `rv32_main_memory`. It accepts one memory operation per cycle and checks alignment and range. It drives the memory request, then returns sign/zero-extended load data or store completion one cycle later, with a skid register for writeback back-pressure. Only one access is in flight at a time; throughput is one access per cycle when writeback never stalls.

## Interface
Parameters:
- none (address range is judged by the memory's `data_ready`)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `resetn`  in  1  reset; asynchronous and active-low
- `req_valid`  in  1  execute stage presents an operation
- `req_ready`  out  1  LSU accepts this cycle
- `req_op`  in  `memory_op_t`  MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, unshifted (memory steers lanes)
- `req_rd`  in  5  destination register tag
- `mem_request`  out  `memory_request_t`  to memory port B (addr, data, op)
- `mem_ready`  in  1  memory `data_ready`: address in range (combinational on addr)
- `mem_data`  in  32  memory port B read word, valid the cycle after the request
- `resp_valid`  out  1  response available
- `resp_ready`  in  1  writeback consumes response
- `resp_data`  out  32  formatted load data; 0 for stores and faults
- `resp_rd`  out  5  tag of the responding access
- `resp_is_load`  out  1  response is a load (writeback enable)
- `resp_fault`  out  `lsu_fault_t`  FAULT_NONE / FAULT_MISALIGNED / FAULT_ACCESS

## Operation
- States: IDLE (nothing pending), WAIT (access issued last cycle, response driven from `mem_data`), HOLD (response captured in skid register, awaiting `resp_ready`).
- Accept = `req_valid && req_ready && req_op != MEM_NOP`.
- `req_ready` = 1 in IDLE; = `resp_ready` in WAIT; = 0 in HOLD.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. Byte ops are never misaligned.
- On accept, `mem_request` = {req_addr, req_wdata, req_op}, combinationally in the same cycle.
- The forwarded op is forced to MEM_NOP if the access is misaligned or `mem_ready`=0. Faulting stores never write.
- When not accepting, `mem_request` = {0, 0, MEM_NOP}.
- Registered at accept: op, addr[1:0], rd, fault. Misaligned takes priority over access fault.
- Load format: LB/LBU select byte addr[1:0], then sign- or zero-extend. LH/LHU select half addr[1], then extend. LW passes the word.
- Transitions:
  - IDLE→WAIT on accept.
  - WAIT→WAIT on accept with `resp_ready`.
  - WAIT→IDLE on `resp_ready` without accept.
  - WAIT→HOLD on `!resp_ready`; the formatted response is latched into the skid register.
  - HOLD→IDLE on `resp_ready`.
- Reset: state IDLE, `resp_valid`=0, `req_ready`=1, `resp_data`=0, `resp_rd`=0, `resp_is_load`=0, `resp_fault`=FAULT_NONE, `mem_request`={0,0,MEM_NOP}. Any in-flight access is dropped and no response is emitted.

## Timing
- Request at cycle T (memory samples the address at the T edge). Response is valid in T+1: load latency 1.
- WAIT: response outputs are combinational from `mem_data` and the registered fields. HOLD: outputs are purely registered.
- Back-to-back: accepting at T+1 while the T response retires is legal; `mem_data` at T+2 belongs to the new access.
- Faulted accesses follow identical timing (response at T+1, `mem_data` ignored).
- A `req_op`=MEM_NOP with `req_valid` is consumed silently: no response, no state change.
- Response held in HOLD indefinitely: outputs stay stable until `resp_ready`.

## Structure
- `rv32_types` package gets `lsu_fault_t` (2-bit enum). It already holds `memory_op_t` and `memory_request_t`, which are reused unchanged.
- State enum is local to the module.
- One combinational sub-module, `rv32_load_formatter` (op, addr[1:0], word → 32-bit result), instantiated once ahead of the skid register.

## Test plan
- LB at 0x103, memory word 0x80FF_1234 → at T+1 `resp_data`=0xFFFF_FF80, `resp_is_load`=1, FAULT_NONE.
- LHU at 0x102 with same word → 0x0000_80FF; LH → 0xFFFF_80FF; LW at 0x100 → 0x80FF_1234.
- SW at 0x101 → `mem_request.op`=MEM_NOP at T; response at T+1 with FAULT_MISALIGNED, `resp_data`=0; memory word unchanged.
- LW beyond range (`mem_ready`=0) → op forced MEM_NOP, FAULT_ACCESS at T+1.
- Back-to-back SW 0xDEADBEEF @0x10 then LW @0x10 with `resp_ready`=1 → responses at T+1 and T+2, second `resp_data`=0xDEADBEEF.
- Load with `resp_ready`=0 for 3 cycles → HOLD, outputs stable, `req_ready`=0. Then `resp_ready` → IDLE. A `resetn` pulse during WAIT → `resp_valid`=0 immediately and no response later.
